control_sequencer: RTL and testbench

- Hardwired control unit that sits directly upstream of Datapath.
- Replaces the hand-sequenced testbench FSMs: fetches each instruction, decodes IR[31:27], and steps T-states emitting Datapath control strobes, one step per clock.
- Outputs are Moore-decoded from the state register plus the latched IR, so Datapath captures on the next posedge.

---
 rtl/cpu_pkg.sv | 76 +++++++
 rtl/cs_decode.sv | 134 +++++++++++++
 rtl/control_sequencer.sv | 112 +++++++++++
 tb/tb_control_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU codes, T-states, strobe bundle.
// MUL_DIV_EN adds mul/div to the set of multi-step opcodes.
package cpu_pkg;

  localparam int IR_W    = 32;
  localparam int OPC_LSB = 27;

  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_ADDI = 5'b01100;
  localparam logic [4:0] OPC_MUL  = 5'b01110;
  localparam logic [4:0] OPC_DIV  = 5'b01111;
  localparam logic [4:0] OPC_BR   = 5'b10010;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_MUL = 4'd5;
  localparam logic [3:0] ALU_DIV = 4'd6;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef struct packed {
    logic pc_out;
    logic zlo_out;
    logic zhi_out;
    logic hi_out;
    logic lo_out;
    logic mdr_out;
    logic mar_enable;
    logic z_enable;
    logic lo_enable;
    logic hi_enable;
    logic pc_enable;
    logic mdr_enable;
    logic read;
    logic ir_enable;
    logic y_enable;
    logic pc_increment;
    logic c_sign_extended_out;
    logic con_enable;
    logic ram_write;
    logic r_in;
    logic r_out;
    logic gra;
    logic grb;
    logic grc;
    logic ba_out;
  } ctrl_t;

  // Final T-state of each opcode; anything unrecognised retires straight after fetch.
  function automatic state_e last_step(input logic [4:0] opc);
    case (opc)
      OPC_LD, OPC_ST:                                  last_step = S_T7;
      OPC_LDI, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_ADDI:                                        last_step = S_T5;
      OPC_BR:                                          last_step = S_T6;
`ifdef MUL_DIV_EN
      OPC_MUL, OPC_DIV:                                last_step = S_T6;
`endif
      default:                                         last_step = S_T2;
    endcase
  endfunction

endpackage

// File: rtl/cs_decode.sv
// Combinational strobe decode from (T-state, opcode, con_ff); mul/div steps exist only under MUL_DIV_EN.
// Zero latency; no backpressure.
module cs_decode
  import cpu_pkg::*;
(
  input  state_e     state_i,
  input  logic [4:0] opc_i,
  input  logic       con_ff_i,
  output ctrl_t      ctrl_o,
  output logic [3:0] alu_op_o,
  output logic       run_o,
  output logic       pc_init_o
);

  always_comb begin
    ctrl_o    = '0;
    alu_op_o  = ALU_NOP;
    run_o     = (state_i != S_RST) && (state_i != S_HALT);
    pc_init_o = (state_i == S_RST);
    case (state_i)
      S_T0: begin
        ctrl_o.pc_out       = 1'b1;
        ctrl_o.mar_enable   = 1'b1;
        ctrl_o.pc_increment = 1'b1;
        ctrl_o.z_enable     = 1'b1;
      end
      S_T1: begin
        ctrl_o.zlo_out    = 1'b1;
        ctrl_o.pc_enable  = 1'b1;
        ctrl_o.read       = 1'b1;
        ctrl_o.mdr_enable = 1'b1;
      end
      S_T2: begin
        ctrl_o.mdr_out   = 1'b1;
        ctrl_o.ir_enable = 1'b1;
      end
      S_T3: begin
        case (opc_i)
          OPC_LD, OPC_LDI, OPC_ST: begin
            ctrl_o.grb = 1'b1; ctrl_o.ba_out = 1'b1; ctrl_o.y_enable = 1'b1;
          end
          OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ADDI: begin
            ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.y_enable = 1'b1;
          end
          OPC_BR: begin
            ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.con_enable = 1'b1;
          end
`ifdef MUL_DIV_EN
          OPC_MUL, OPC_DIV: begin
            ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.y_enable = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T4: begin
        case (opc_i)
          OPC_LD, OPC_LDI, OPC_ST, OPC_ADDI: begin
            ctrl_o.c_sign_extended_out = 1'b1; ctrl_o.z_enable = 1'b1; alu_op_o = ALU_ADD;
          end
          OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: begin
            ctrl_o.grc = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.z_enable = 1'b1;
            case (opc_i)
              OPC_ADD: alu_op_o = ALU_ADD;
              OPC_SUB: alu_op_o = ALU_SUB;
              OPC_AND: alu_op_o = ALU_AND;
              default: alu_op_o = ALU_OR;
            endcase
          end
          OPC_BR: begin
            ctrl_o.pc_out = 1'b1; ctrl_o.y_enable = 1'b1;
          end
`ifdef MUL_DIV_EN
          OPC_MUL, OPC_DIV: begin
            ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.z_enable = 1'b1;
            alu_op_o = (opc_i == OPC_MUL) ? ALU_MUL : ALU_DIV;
          end
`endif
          default: ;
        endcase
      end
      S_T5: begin
        case (opc_i)
          OPC_LD, OPC_ST: begin
            ctrl_o.zlo_out = 1'b1; ctrl_o.mar_enable = 1'b1;
          end
          OPC_LDI, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ADDI: begin
            ctrl_o.zlo_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1;
          end
          OPC_BR: begin
            ctrl_o.c_sign_extended_out = 1'b1; ctrl_o.z_enable = 1'b1; alu_op_o = ALU_ADD;
          end
`ifdef MUL_DIV_EN
          OPC_MUL, OPC_DIV: begin
            ctrl_o.zlo_out = 1'b1; ctrl_o.lo_enable = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T6: begin
        case (opc_i)
          OPC_LD: begin
            ctrl_o.read = 1'b1; ctrl_o.mdr_enable = 1'b1;
          end
          OPC_ST: begin
            ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.mdr_enable = 1'b1;
          end
          OPC_BR: begin
            // Branch taken only when the CON flip-flop is set during this step.
            ctrl_o.zlo_out = 1'b1; ctrl_o.pc_enable = con_ff_i;
          end
`ifdef MUL_DIV_EN
          OPC_MUL, OPC_DIV: begin
            ctrl_o.zhi_out = 1'b1; ctrl_o.hi_enable = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T7: begin
        case (opc_i)
          OPC_LD: begin
            ctrl_o.mdr_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1;
          end
          OPC_ST: ctrl_o.ram_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving Datapath strobes, one T-step per clock (MUL_DIV_EN adds mul/div).
// Moore outputs, zero latency from state; no backpressure, stop only acts on an instruction's last step.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int IR_W    = cpu_pkg::IR_W,
  parameter int OPC_LSB = cpu_pkg::OPC_LSB
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [IR_W-1:0] ir,
  input  logic            con_ff,
  input  logic            stop,
  output logic            run,
  output logic            pc_init_enable,
  output logic [3:0]      alu_op,
  output logic            pc_out,
  output logic            zlo_out,
  output logic            zhi_out,
  output logic            hi_out,
  output logic            lo_out,
  output logic            mdr_out,
  output logic            mar_enable,
  output logic            z_enable,
  output logic            lo_enable,
  output logic            hi_enable,
  output logic            pc_enable,
  output logic            mdr_enable,
  output logic            read,
  output logic            ir_enable,
  output logic            y_enable,
  output logic            pc_increment,
  output logic            c_sign_extended_out,
  output logic            con_enable,
  output logic            ram_write,
  output logic            r_in,
  output logic            r_out,
  output logic            gra,
  output logic            grb,
  output logic            grc,
  output logic            ba_out
);

  state_e     state_q, state_d;
  logic [4:0] opc;
  ctrl_t      ctrl;
  logic       pc_init;
  logic       unused_ir;

  assign opc       = ir[OPC_LSB +: 5];
  assign unused_ir = ^ir;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_RST;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: begin
        if (state_q == S_T2 && opc == OPC_HALT)
          state_d = S_HALT;
        else if (state_q == last_step(opc))
          state_d = stop ? S_HALT : S_T0;
        else
          state_d = state_e'(state_q + 4'd1);
      end
    endcase
  end

  cs_decode u_decode (
    .state_i   (state_q),
    .opc_i     (opc),
    .con_ff_i  (con_ff),
    .ctrl_o    (ctrl),
    .alu_op_o  (alu_op),
    .run_o     (run),
    .pc_init_o (pc_init)
  );

  // Held in RST by clr the preset stays low; it pulses for the first cycle after release.
  assign pc_init_enable      = pc_init & clr;
  assign pc_out              = ctrl.pc_out;
  assign zlo_out             = ctrl.zlo_out;
  assign zhi_out             = ctrl.zhi_out;
  assign hi_out              = ctrl.hi_out;
  assign lo_out              = ctrl.lo_out;
  assign mdr_out             = ctrl.mdr_out;
  assign mar_enable          = ctrl.mar_enable;
  assign z_enable            = ctrl.z_enable;
  assign lo_enable           = ctrl.lo_enable;
  assign hi_enable           = ctrl.hi_enable;
  assign pc_enable           = ctrl.pc_enable;
  assign mdr_enable          = ctrl.mdr_enable;
  assign read                = ctrl.read;
  assign ir_enable           = ctrl.ir_enable;
  assign y_enable            = ctrl.y_enable;
  assign pc_increment        = ctrl.pc_increment;
  assign c_sign_extended_out = ctrl.c_sign_extended_out;
  assign con_enable          = ctrl.con_enable;
  assign ram_write           = ctrl.ram_write;
  assign r_in                = ctrl.r_in;
  assign r_out               = ctrl.r_out;
  assign gra                 = ctrl.gra;
  assign grb                 = ctrl.grb;
  assign grc                 = ctrl.grc;
  assign ba_out              = ctrl.ba_out;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-opcode strobe sequences, stop/halt, async reset abort.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] ir = 32'h0;
  logic        con_ff = 1'b0;
  logic        stop = 1'b0;
  logic        run, pc_init_enable;
  logic [3:0]  alu_op;
  logic pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, mar_enable, z_enable;
  logic lo_enable, hi_enable, pc_enable, mdr_enable, read, ir_enable, y_enable;
  logic pc_increment, c_sign_extended_out, con_enable, ram_write, r_in, r_out;
  logic gra, grb, grc, ba_out;
  logic [24:0] sv;

  int vecs = 0;
  int errs = 0;

  localparam logic [24:0] PC_OUT  = 25'h1 << 24;
  localparam logic [24:0] ZLO     = 25'h1 << 23;
  localparam logic [24:0] ZHI     = 25'h1 << 22;
  localparam logic [24:0] MDR_OUT = 25'h1 << 19;
  localparam logic [24:0] MAR_EN  = 25'h1 << 18;
  localparam logic [24:0] Z_EN    = 25'h1 << 17;
  localparam logic [24:0] LO_EN   = 25'h1 << 16;
  localparam logic [24:0] HI_EN   = 25'h1 << 15;
  localparam logic [24:0] PC_EN   = 25'h1 << 14;
  localparam logic [24:0] MDR_EN  = 25'h1 << 13;
  localparam logic [24:0] READ    = 25'h1 << 12;
  localparam logic [24:0] IR_EN   = 25'h1 << 11;
  localparam logic [24:0] Y_EN    = 25'h1 << 10;
  localparam logic [24:0] PC_INC  = 25'h1 << 9;
  localparam logic [24:0] CSE     = 25'h1 << 8;
  localparam logic [24:0] CON_EN  = 25'h1 << 7;
  localparam logic [24:0] RAM_WR  = 25'h1 << 6;
  localparam logic [24:0] R_IN    = 25'h1 << 5;
  localparam logic [24:0] R_OUT   = 25'h1 << 4;
  localparam logic [24:0] GRA     = 25'h1 << 3;
  localparam logic [24:0] GRB     = 25'h1 << 2;
  localparam logic [24:0] GRC     = 25'h1 << 1;
  localparam logic [24:0] BA_OUT  = 25'h1;
  localparam logic [24:0] F0 = PC_OUT | MAR_EN | PC_INC | Z_EN;
  localparam logic [24:0] F1 = ZLO | PC_EN | READ | MDR_EN;
  localparam logic [24:0] F2 = MDR_OUT | IR_EN;

  assign sv = {pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, mar_enable, z_enable,
               lo_enable, hi_enable, pc_enable, mdr_enable, read, ir_enable, y_enable,
               pc_increment, c_sign_extended_out, con_enable, ram_write, r_in, r_out,
               gra, grb, grc, ba_out};

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
    .run(run), .pc_init_enable(pc_init_enable), .alu_op(alu_op),
    .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .hi_out(hi_out), .lo_out(lo_out),
    .mdr_out(mdr_out), .mar_enable(mar_enable), .z_enable(z_enable), .lo_enable(lo_enable),
    .hi_enable(hi_enable), .pc_enable(pc_enable), .mdr_enable(mdr_enable), .read(read),
    .ir_enable(ir_enable), .y_enable(y_enable), .pc_increment(pc_increment),
    .c_sign_extended_out(c_sign_extended_out), .con_enable(con_enable), .ram_write(ram_write),
    .r_in(r_in), .r_out(r_out), .gra(gra), .grb(grb), .grc(grc), .ba_out(ba_out)
  );

  always #5 clk = ~clk;

  // Reset, release, and leave the bench sampling in T2 of the first fetch.
  task automatic restart(input logic [31:0] ir_v, input logic con_v, input logic stop_v);
    @(negedge clk);
    clr = 1'b0; ir = ir_v; con_ff = con_v; stop = stop_v;
    @(negedge clk);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [24:0] es[3];
    es = '{F0, F1, F2};
    clr = 1'b0; ir = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    vecs++;
    if (sv !== 25'h0 || run !== 1'b0 || pc_init_enable !== 1'b0 || alu_op !== 4'd0) begin
      errs++;
      $display("FAIL reset_held strobes=%h run=%b pci=%b alu=%0d expected all zero", sv, run, pc_init_enable, alu_op);
    end
    clr = 1'b1;
    #1;
    vecs++;
    if (sv !== 25'h0 || run !== 1'b0 || pc_init_enable !== 1'b1) begin
      errs++;
      $display("FAIL rst_state strobes=%h run=%b pci=%b expected strobes=0 run=0 pci=1", sv, run, pc_init_enable);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      vecs++;
      if (sv !== es[k] || run !== 1'b1 || pc_init_enable !== 1'b0 || alu_op !== 4'd0) begin
        errs++;
        $display("FAIL fetch_T%0d strobes=%h run=%b pci=%b expected strobes=%h run=1 pci=0", k, sv, run, pc_init_enable, es[k]);
      end
    end
  endtask

  task automatic test_ld();
    logic [24:0] es[5];
    logic [3:0]  ea[5];
    es = '{GRB | BA_OUT | Y_EN, CSE | Z_EN, ZLO | MAR_EN, READ | MDR_EN, MDR_OUT | GRA | R_IN};
    ea = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
    restart(32'h0080_0000, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      vecs++;
      if (sv !== es[k] || alu_op !== ea[k] || run !== 1'b1) begin
        errs++;
        $display("FAIL ld_T%0d strobes=%h alu=%0d run=%b expected strobes=%h alu=%0d run=1", k + 3, sv, alu_op, run, es[k], ea[k]);
      end
    end
    @(negedge clk); #1;
    vecs++;
    if (sv !== F0 || run !== 1'b1) begin
      errs++;
      $display("FAIL ld_back_to_T0 strobes=%h run=%b expected strobes=%h run=1", sv, run, F0);
    end
  endtask

  task automatic test_st();
    logic [24:0] es[6];
    logic [3:0]  ea[6];
    es = '{GRB | BA_OUT | Y_EN, CSE | Z_EN, ZLO | MAR_EN, GRA | R_OUT | MDR_EN, RAM_WR, F0};
    ea = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    restart(32'h1000_0005, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      vecs++;
      if (sv !== es[k] || alu_op !== ea[k]) begin
        errs++;
        $display("FAIL st_step%0d strobes=%h alu=%0d expected strobes=%h alu=%0d", k + 3, sv, alu_op, es[k], ea[k]);
      end
    end
  endtask

  task automatic test_alu();
    logic [31:0] irs[5];
    logic [3:0]  alus[5];
    logic [24:0] t4s[5];
    irs  = '{32'h1800_0000, 32'h2000_0000, 32'h2800_0000, 32'h3000_0000, 32'h6000_0000};
    alus = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    t4s  = '{GRC | R_OUT | Z_EN, GRC | R_OUT | Z_EN, GRC | R_OUT | Z_EN, GRC | R_OUT | Z_EN, CSE | Z_EN};
    for (int i = 0; i < 5; i++) begin
      restart(irs[i], 1'b0, 1'b0);
      @(negedge clk); #1;
      vecs++;
      if (sv !== (GRB | R_OUT | Y_EN) || alu_op !== 4'd0) begin
        errs++;
        $display("FAIL alu%0d_T3 strobes=%h alu=%0d expected strobes=%h alu=0", i, sv, alu_op, GRB | R_OUT | Y_EN);
      end
      @(negedge clk); #1;
      vecs++;
      if (sv !== t4s[i] || alu_op !== alus[i]) begin
        errs++;
        $display("FAIL alu%0d_T4 strobes=%h alu=%0d expected strobes=%h alu=%0d", i, sv, alu_op, t4s[i], alus[i]);
      end
      @(negedge clk); #1;
      vecs++;
      if (sv !== (ZLO | GRA | R_IN) || alu_op !== 4'd0) begin
        errs++;
        $display("FAIL alu%0d_T5 strobes=%h alu=%0d expected strobes=%h alu=0", i, sv, alu_op, ZLO | GRA | R_IN);
      end
      @(negedge clk); #1;
      vecs++;
      if (sv !== F0) begin
        errs++;
        $display("FAIL alu%0d_back_to_T0 strobes=%h expected %h", i, sv, F0);
      end
    end
  endtask

  task automatic test_br();
    logic [24:0] es[5];
    logic [3:0]  ea[5];
    for (int c = 0; c < 2; c++) begin
      es = '{GRA | R_OUT | CON_EN, PC_OUT | Y_EN, CSE | Z_EN, ZLO | ((c == 1) ? PC_EN : 25'h0), F0};
      ea = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd0};
      restart(32'h9000_0000, (c == 1), 1'b0);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk); #1;
        vecs++;
        if (sv !== es[k] || alu_op !== ea[k]) begin
          errs++;
          $display("FAIL br_con%0d_step%0d strobes=%h alu=%0d expected strobes=%h alu=%0d", c, k + 3, sv, alu_op, es[k], ea[k]);
        end
      end
    end
  endtask

  task automatic test_ldi_stop();
    logic [24:0] es[5];
    logic [3:0]  ea[5];
    logic        er[5];
    es = '{GRB | BA_OUT | Y_EN, CSE | Z_EN, ZLO | GRA | R_IN, 25'h0, 25'h0};
    ea = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
    er = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    restart(32'h0800_0000, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      vecs++;
      if (sv !== es[k] || alu_op !== ea[k] || run !== er[k]) begin
        errs++;
        $display("FAIL ldi_stop_step%0d strobes=%h alu=%0d run=%b expected strobes=%h alu=%0d run=%b", k + 3, sv, alu_op, run, es[k], ea[k], er[k]);
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_nop();
`ifdef MUL_DIV_EN
    logic [31:0] irs[2];
    irs = '{32'hD000_0000, 32'hF800_0000};
    for (int i = 0; i < 2; i++) begin
`else
    logic [31:0] irs[4];
    irs = '{32'hD000_0000, 32'hF800_0000, 32'h7000_0000, 32'h7800_0000};
    for (int i = 0; i < 4; i++) begin
`endif
      restart(irs[i], 1'b0, 1'b0);
      @(negedge clk); #1;
      vecs++;
      if (sv !== F0 || run !== 1'b1) begin
        errs++;
        $display("FAIL nop%0d_retire strobes=%h run=%b expected strobes=%h run=1", i, sv, run, F0);
      end
    end
  endtask

  task automatic test_halt();
    int bad;
    bad = 0;
    restart(32'hD800_0000, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (sv !== 25'h0 || run !== 1'b0 || alu_op !== 4'd0 || pc_init_enable !== 1'b0) bad++;
    end
    vecs++;
    if (bad != 0) begin
      errs++;
      $display("FAIL halt_absorb bad_cycles=%0d expected 0", bad);
    end
    clr = 1'b0; #2; clr = 1'b1; #1;
    vecs++;
    if (pc_init_enable !== 1'b1 || run !== 1'b0 || sv !== 25'h0) begin
      errs++;
      $display("FAIL halt_clr_to_rst pci=%b run=%b strobes=%h expected pci=1 run=0 strobes=0", pc_init_enable, run, sv);
    end
    @(negedge clk); #1;
    vecs++;
    if (sv !== F0 || run !== 1'b1) begin
      errs++;
      $display("FAIL halt_restart_T0 strobes=%h run=%b expected strobes=%h run=1", sv, run, F0);
    end
  endtask

  task automatic test_abort();
    restart(32'h1800_0000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    vecs++;
    if (sv !== (ZLO | GRA | R_IN)) begin
      errs++;
      $display("FAIL abort_pre_T5 strobes=%h expected %h", sv, ZLO | GRA | R_IN);
    end
    clr = 1'b0; #1;
    vecs++;
    if (sv !== 25'h0 || run !== 1'b0 || alu_op !== 4'd0 || pc_init_enable !== 1'b0) begin
      errs++;
      $display("FAIL abort_async strobes=%h run=%b alu=%0d pci=%b expected all zero", sv, run, alu_op, pc_init_enable);
    end
    @(negedge clk);
    clr = 1'b1; #1;
    vecs++;
    if (pc_init_enable !== 1'b1 || sv !== 25'h0) begin
      errs++;
      $display("FAIL abort_rst pci=%b strobes=%h expected pci=1 strobes=0", pc_init_enable, sv);
    end
  endtask

`ifdef MUL_DIV_EN
  task automatic test_muldiv();
    logic [31:0] irs[2];
    logic [3:0]  ops[2];
    logic [24:0] es[5];
    irs = '{32'h7000_0000, 32'h7800_0000};
    ops = '{4'd5, 4'd6};
    es  = '{GRA | R_OUT | Y_EN, GRB | R_OUT | Z_EN, ZLO | LO_EN, ZHI | HI_EN, F0};
    for (int i = 0; i < 2; i++) begin
      restart(irs[i], 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk); #1;
        vecs++;
        if (sv !== es[k] || alu_op !== ((k == 1) ? ops[i] : 4'd0)) begin
          errs++;
          $display("FAIL muldiv%0d_step%0d strobes=%h alu=%0d expected strobes=%h alu=%0d", i, k + 3, sv, alu_op, es[k], (k == 1) ? ops[i] : 4'd0);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ld();
    test_st();
    test_alu();
    test_br();
    test_ldi_stop();
    test_nop();
    test_halt();
    test_abort();
`ifdef MUL_DIV_EN
    test_muldiv();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
